sirv_gnrl_elastic_buf: RTL

Parametrised multi-entry successor to the single load-enable register. It is a DP-deep, DW-wide elastic pipeline buffer with valid/ready handshakes on both sides, an optional registered-ready (cut) mode, synchronous flush and an occupancy count. It sits between producer and consumer pipeline stages (e.g. IFU→EXU, LSU→BIU) to decouple timing and absorb backpressure.

---
 rtl/sirv_gnrl_elastic_buf.sv | 110 +++++++++++
 1 files changed

// File: rtl/sirv_gnrl_elastic_buf.sv
// DP-deep, DW-wide elastic pipeline buffer with valid/ready on both sides.
// Circular storage, dedicated occupancy counter, optional registered-ready mode and synchronous flush.
module sirv_gnrl_elastic_buf #(
  parameter int DW        = 32,
  parameter int DP        = 2,
  parameter int CUT_READY = 1,
  localparam int CW       = $clog2(DP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  input  logic          flush,
  output logic [CW-1:0] cnt
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;

  logic [DW-1:0] mem_q [DP];
  logic [DW-1:0] mem_d [DP];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // With DP=1 the compare against DP-1 is against 0, so pointers stay at 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full  = (cnt_q == CW'(DP));
    empty = (cnt_q == '0);
    o_vld = ~empty;
    o_dat = mem_q[rptr_q];
    cnt   = cnt_q;
    if (CUT_READY != 0) begin
      i_rdy = ~full & ~flush;
    end else begin
      i_rdy = (~full | o_rdy) & ~flush;
    end
    push = i_vld & i_rdy;
    pop  = o_vld & o_rdy;
  end

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < DP; i++) begin
      mem_d[i] = mem_q[i];
      if (push && (wptr_q == PW'(i))) begin
        mem_d[i] = i_dat;
      end
    end
    // Flush wins over any pop in the same cycle; storage contents are left as-is.
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DP; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < DP; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CW'(DP));

  a_ptr_consistent : assert property (@(posedge clk) disable iff (!rst_n)
    wptr_q == PW'((int'(rptr_q) + int'(cnt_q)) % DP));

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !(pop && (CUT_READY == 0))));

endmodule
